fp_mult_link: RTL and testbench

FP_MULT_LINK -- requirements
Module: fp_mult_link

---
 rtl/fp_link_pkg.sv | 14 +
 rtl/fp_link_watchdog.sv | 32 +++
 rtl/fp_mult_link.sv | 168 ++++++++++++++++
 tb/tb_fp_mult_link.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_link_pkg.sv
// Shared types and constants for the byte-serial FP multiplier link.
package fp_link_pkg;
   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_WAIT,
      S_COLLECT,
      S_DONE
   } state_e;

   localparam int          OPERAND_BYTES = 16;
   localparam int          RESULT_BYTES  = 8;
   localparam logic [63:0] QNAN_DEFAULT  = 64'h7FF8_0000_0000_0000;
endpackage

// File: rtl/fp_link_watchdog.sv
// Saturating idle-cycle watchdog; expired once TIMEOUT enabled cycles elapse.
module fp_link_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);
   localparam int             W     = $clog2(TIMEOUT + 1);
   localparam logic [W-1:0]   LIMIT = W'(TIMEOUT);

   logic [W-1:0] cnt_q, cnt_d;

   // Clear wins; otherwise count up and stop at the limit (never wraps).
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if (enable_i && (cnt_q != LIMIT))
         cnt_d = cnt_q + W'(1);
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign expired_o = (cnt_q == LIMIT);
endmodule

// File: rtl/fp_mult_link.sv
// Serialises two doubles LSB-first to a byte-serial multiplier and
// reassembles the 8-byte product, with a watchdog abort returning QNAN.
module fp_mult_link
   import fp_link_pkg::*;
#(
   parameter int          TIMEOUT = 64,
   parameter logic [63:0] QNAN    = QNAN_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        op_valid_i,
   output logic        op_ready_o,
   input  logic [63:0] op_a_i,
   input  logic [63:0] op_b_i,
   output logic        mul_reset_o,
   output logic        mul_enable_o,
   output logic [7:0]  mul_data_o,
   input  logic        mul_ready_i,
   input  logic [7:0]  mul_data_in_i,
   output logic        res_valid_o,
   input  logic        res_ready_i,
   output logic [63:0] res_data_o,
   output logic        res_timeout_o
);
   state_e        state_q, state_d;
   logic          op_ready_q, op_ready_d;
   logic          mul_reset_q, mul_reset_d;
   logic          mul_enable_q, mul_enable_d;
   logic [7:0]    mul_data_q, mul_data_d;
   logic          res_valid_q, res_valid_d;
   logic [63:0]   res_data_q, res_data_d;
   logic          res_timeout_q, res_timeout_d;
   logic [127:0]  opnd_q, opnd_d;
   logic [4:0]    cnt_q, cnt_d;
   logic          started_q;
   logic          wd_active, wd_expired;

   // Watchdog runs only while awaiting result bytes; every result byte rearms it.
   assign wd_active = (state_q == S_WAIT) || (state_q == S_COLLECT);

   fp_link_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (!wd_active || mul_ready_i),
      .enable_i  (wd_active),
      .expired_o (wd_expired)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d       = state_q;
      op_ready_d    = 1'b0;
      mul_reset_d   = !started_q;   // hold multiplier reset one cycle past release
      mul_enable_d  = 1'b0;
      mul_data_d    = mul_data_q;
      res_valid_d   = res_valid_q;
      res_data_d    = res_data_q;
      res_timeout_d = res_timeout_q;
      opnd_d        = opnd_q;
      cnt_d         = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            op_ready_d = 1'b1;
            if (op_valid_i && op_ready_q) begin
               // Byte 0 goes out on the edge that accepts the operands.
               op_ready_d   = 1'b0;
               mul_enable_d = 1'b1;
               mul_data_d   = op_a_i[7:0];
               opnd_d       = {8'h00, op_b_i, op_a_i[63:8]};
               cnt_d        = 5'd1;
               state_d      = S_SEND;
            end
         end
         S_SEND: begin
            if (cnt_q == 5'(OPERAND_BYTES)) begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end else begin
               mul_enable_d = 1'b1;
               mul_data_d   = opnd_q[7:0];
               opnd_d       = {8'h00, opnd_q[127:8]};
               cnt_d        = cnt_q + 5'd1;
            end
         end
         S_WAIT: begin
            if (mul_ready_i) begin
               res_data_d[7:0] = mul_data_in_i;
               cnt_d           = 5'd1;
               state_d         = S_COLLECT;
            end else if (wd_expired) begin
               mul_reset_d   = 1'b1;
               res_data_d    = QNAN;
               res_timeout_d = 1'b1;
               res_valid_d   = 1'b1;
               state_d       = S_DONE;
            end
         end
         S_COLLECT: begin
            if (mul_ready_i) begin
               res_data_d[{cnt_q[2:0], 3'b000} +: 8] = mul_data_in_i;
               if (cnt_q == 5'(RESULT_BYTES - 1)) begin
                  res_valid_d   = 1'b1;
                  res_timeout_d = 1'b0;
                  cnt_d         = '0;
                  state_d       = S_DONE;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end else if (wd_expired) begin
               mul_reset_d   = 1'b1;
               res_data_d    = QNAN;
               res_timeout_d = 1'b1;
               res_valid_d   = 1'b1;
               cnt_d         = '0;
               state_d       = S_DONE;
            end
         end
         S_DONE: begin
            // Late result bytes keep us here so they never leak into the next op.
            if (res_valid_q && res_ready_i)
               res_valid_d = 1'b0;
            if ((!res_valid_q || res_ready_i) && !mul_ready_i) begin
               res_valid_d = 1'b0;
               op_ready_d  = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= S_IDLE;
         op_ready_q    <= 1'b0;
         mul_reset_q   <= 1'b1;
         mul_enable_q  <= 1'b0;
         mul_data_q    <= '0;
         res_valid_q   <= 1'b0;
         res_data_q    <= '0;
         res_timeout_q <= 1'b0;
         opnd_q        <= '0;
         cnt_q         <= '0;
         started_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_ready_q    <= op_ready_d;
         mul_reset_q   <= mul_reset_d;
         mul_enable_q  <= mul_enable_d;
         mul_data_q    <= mul_data_d;
         res_valid_q   <= res_valid_d;
         res_data_q    <= res_data_d;
         res_timeout_q <= res_timeout_d;
         opnd_q        <= opnd_d;
         cnt_q         <= cnt_d;
         started_q     <= 1'b1;
      end
   end

   assign op_ready_o    = op_ready_q;
   assign mul_reset_o   = mul_reset_q;
   assign mul_enable_o  = mul_enable_q;
   assign mul_data_o    = mul_data_q;
   assign res_valid_o   = res_valid_q;
   assign res_data_o    = res_data_q;
   assign res_timeout_o = res_timeout_q;
endmodule

// File: tb/tb_fp_mult_link.sv
// Directed bench for fp_mult_link with an inline byte-serial multiplier model.
module tb_fp_mult_link;
   logic        clk, rst_n;
   logic        op_valid, op_ready;
   logic [63:0] op_a, op_b;
   logic        mul_reset, mul_enable, mul_ready;
   logic [7:0]  mul_data, mul_data_in;
   logic        res_valid, res_ready, res_timeout;
   logic [63:0] res_data;

   int checks = 0;
   int errors = 0;

   fp_mult_link #(.TIMEOUT(64), .QNAN(64'h7FF8_0000_0000_0000)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .op_valid_i(op_valid), .op_ready_o(op_ready),
      .op_a_i(op_a), .op_b_i(op_b),
      .mul_reset_o(mul_reset), .mul_enable_o(mul_enable), .mul_data_o(mul_data),
      .mul_ready_i(mul_ready), .mul_data_in_i(mul_data_in),
      .res_valid_o(res_valid), .res_ready_i(res_ready),
      .res_data_o(res_data), .res_timeout_o(res_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Offer one operand pair; returns on the negedge after the handshake edge.
   task automatic send_op(input logic [63:0] a, input logic [63:0] b);
      int n = 0;
      while (!op_ready && n < 50) begin @(negedge clk); n++; end
      chk("op_ready_before_send", op_ready, 1'b1);
      op_valid = 1'b1; op_a = a; op_b = b;
      @(posedge clk);
      @(negedge clk);
      op_valid = 1'b0;
   endtask

   // Capture operand bytes as the multiplier would, stopping after 'stop' bytes.
   task automatic collect(input int stop, output logic [127:0] got);
      int n = 0, t = 0;
      got = '0;
      while (n < stop && t < 60) begin
         if (mul_enable) begin got[8*n +: 8] = mul_data; n++; end
         if (n < stop) begin @(negedge clk); t++; end
      end
      chk("send_byte_count", 32'(n), 32'(stop));
   endtask

   // Return result bytes LSB first; optional one-cycle gap after byte 'gap_after'.
   task automatic emit(input logic [63:0] w, input int nbytes, input int gap_after);
      logic [63:0] wv;
      wv = w;
      for (int i = 0; i < nbytes; i++) begin
         mul_ready   = 1'b1;
         mul_data_in = (i < 8) ? wv[8*i +: 8] : 8'hEE;
         @(negedge clk);
         if (i == gap_after) begin mul_ready = 1'b0; @(negedge clk); end
      end
      mul_ready = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!res_valid && n < 200) begin @(negedge clk); n++; end
      chk(tag, res_valid, 1'b1);
   endtask

   task automatic handshake();
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
      chk("idle_after_handshake", op_ready, 1'b1);
      chk("valid_drop_after_handshake", res_valid, 1'b0);
   endtask

   initial begin
      logic [127:0] got;
      int n, mr, vcnt;
      rst_n = 1'b1; op_valid = 0; op_a = 0; op_b = 0;
      mul_ready = 0; mul_data_in = 0; res_ready = 0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);

      // Reset values
      chk("rst_op_ready", op_ready, 1'b0);
      chk("rst_mul_reset", mul_reset, 1'b1);
      chk("rst_mul_enable", mul_enable, 1'b0);
      chk("rst_mul_data", mul_data, 8'h00);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_res_timeout", res_timeout, 1'b0);
      chk("rst_res_data", res_data, 64'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_op_ready", op_ready, 1'b1);
      chk("post_rst_mul_reset_hold", mul_reset, 1'b1);
      @(negedge clk);
      chk("post_rst_mul_reset_clear", mul_reset, 1'b0);

      // Result strobes while idle must be ignored
      mul_ready = 1'b1; mul_data_in = 8'h55;
      repeat (4) @(negedge clk);
      mul_ready = 1'b0;
      chk("idle_ready_ignored_valid", res_valid, 1'b0);
      chk("idle_ready_ignored_op_ready", op_ready, 1'b1);

      // 1.5 * 2.0 = 3.0
      send_op(64'h3FF8_0000_0000_0000, 64'h4000_0000_0000_0000);
      chk("send_op_ready_low", op_ready, 1'b0);
      chk("send_first_byte_enable", mul_enable, 1'b1);
      collect(16, got);
      chk("send_bytes_1p5x2", got, {64'h4000_0000_0000_0000, 64'h3FF8_0000_0000_0000});
      @(negedge clk);
      chk("send_enable_stops_after_16", mul_enable, 1'b0);
      emit(64'h4008_0000_0000_0000, 8, -1);
      wait_valid("valid_1p5x2");
      chk("res_1p5x2", res_data, 64'h4008_0000_0000_0000);
      chk("tmo_1p5x2", res_timeout, 1'b0);
      handshake();

      // NaN payload passthrough plus consumer backpressure
      send_op(64'h7FF8_0000_0000_0001, 64'h3FF0_0000_0000_0000);
      collect(16, got);
      chk("send_bytes_nan", got, {64'h3FF0_0000_0000_0000, 64'h7FF8_0000_0000_0001});
      @(negedge clk);
      emit(64'h7FF8_0000_0000_0001, 8, -1);
      wait_valid("valid_nan");
      for (int i = 0; i < 5; i++) begin
         chk("bp_res_data", res_data, 64'h7FF8_0000_0000_0001);
         chk("bp_res_valid", res_valid, 1'b1);
         chk("bp_op_ready", op_ready, 1'b0);
         @(negedge clk);
      end
      handshake();

      // Silent multiplier: watchdog abort after 64 idle WAIT cycles
      send_op(64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000);
      collect(16, got);
      @(negedge clk);
      n = 0; mr = 0;
      while (!res_valid && n < 200) begin
         @(negedge clk); n++;
         if (mul_reset && !res_valid) mr++;
      end
      chk("tmo_latency", 32'(n), 32'd65);
      chk("tmo_no_early_reset", 32'(mr), 32'd0);
      chk("tmo_mul_reset_pulse", mul_reset, 1'b1);
      chk("tmo_res_data", res_data, 64'h7FF8_0000_0000_0000);
      chk("tmo_flag", res_timeout, 1'b1);
      @(negedge clk);
      chk("tmo_mul_reset_one_cycle", mul_reset, 1'b0);
      handshake();

      // Reset during SEND discards the transfer
      send_op(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
      collect(9, got);
      rst_n = 1'b0;
      #1;
      chk("midrst_mul_reset", mul_reset, 1'b1);
      chk("midrst_mul_enable", mul_enable, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      vcnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (res_valid) vcnt++;
      end
      chk("midrst_no_result", 32'(vcnt), 32'd0);
      send_op(64'h3FF8_0000_0000_0000, 64'h4000_0000_0000_0000);
      collect(16, got);
      chk("midrst_next_bytes", got, {64'h4000_0000_0000_0000, 64'h3FF8_0000_0000_0000});
      @(negedge clk);
      emit(64'h4008_0000_0000_0000, 8, -1);
      wait_valid("valid_after_midrst");
      chk("res_after_midrst", res_data, 64'h4008_0000_0000_0000);
      handshake();

      // Nine result bytes with a gap after byte 3; ninth is dropped
      send_op(64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000);
      collect(16, got);
      @(negedge clk);
      emit(64'h0123_4567_89AB_CDEF, 9, 3);
      wait_valid("valid_gap9");
      chk("res_gap9", res_data, 64'h0123_4567_89AB_CDEF);
      chk("tmo_gap9", res_timeout, 1'b0);
      // Handshake while a stray strobe is high: stay out of IDLE until it drops
      mul_ready = 1'b1; res_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("done_stray_valid", res_valid, 1'b0);
      chk("done_stray_op_ready", op_ready, 1'b0);
      mul_ready = 1'b0; res_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("done_stray_to_idle", op_ready, 1'b1);
      chk("res_gap9_held", res_data, 64'h0123_4567_89AB_CDEF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
